// File: rtl/srpt_grant_recv_pkg.sv
// Shared widths, field positions, table entry type and FSM states for the
// Homa grant receive path.
package homa_grant_pkg;

  localparam int PEER_ID_W    = 14;
  localparam int RPC_ID_W     = 14;
  localparam int OFFSET_W     = 10;
  localparam int PRIO_W       = 3;

  localparam int GRANT_PKT_W  = 51;
  localparam int RPC_REG_W    = 38;
  localparam int SEND_READY_W = 51;

  // Grant packet: peer | rpc | offset | priority | reserved
  localparam int GP_PEER_LSB  = 37;
  localparam int GP_RPC_LSB   = 23;
  localparam int GP_OFF_LSB   = 13;
  localparam int GP_PRIO_LSB  = 10;

  // Registration word: peer | rpc | msg_len
  localparam int RR_PEER_LSB  = 24;
  localparam int RR_RPC_LSB   = 10;
  localparam int RR_LEN_LSB   = 0;

  // Send-ready record: peer | rpc | priority | prev_grant | new_grant
  localparam int SR_PEER_LSB  = 37;
  localparam int SR_RPC_LSB   = 23;
  localparam int SR_PRIO_LSB  = 20;
  localparam int SR_PREV_LSB  = 10;
  localparam int SR_NEW_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    UPDATE,
    EMIT
  } state_e;

  typedef struct packed {
    logic [RPC_ID_W-1:0]  tag;
    logic [PEER_ID_W-1:0] peer;
    logic [OFFSET_W-1:0]  msg_len;
    logic [OFFSET_W-1:0]  granted;
  } rpc_entry_t;

  function automatic logic [OFFSET_W-1:0] clamp_grant(input logic [OFFSET_W-1:0] offset,
                                                      input logic [OFFSET_W-1:0] msg_len);
    return (offset < msg_len) ? offset : msg_len;
  endfunction

endpackage

// File: rtl/srpt_grant_recv_if.sv
// Bus bundle of the grant receiver: grant FIFO pop side, RPC registration
// port and scheduler FIFO push side. Suffixes are from the receiver's view.
interface srpt_grant_recv_if;

  logic                                    grant_pkt_empty_i;
  logic [homa_grant_pkg::GRANT_PKT_W-1:0]  grant_pkt_data_i;
  logic                                    grant_pkt_read_en_o;

  logic                                    rpc_reg_valid_i;
  logic [homa_grant_pkg::RPC_REG_W-1:0]    rpc_reg_data_i;
  logic                                    rpc_reg_ready_o;

  logic                                    send_ready_full_i;
  logic [homa_grant_pkg::SEND_READY_W-1:0] send_ready_data_o;
  logic                                    send_ready_write_en_o;

  modport slave (
    input  grant_pkt_empty_i, grant_pkt_data_i,
    input  rpc_reg_valid_i, rpc_reg_data_i,
    input  send_ready_full_i,
    output grant_pkt_read_en_o, rpc_reg_ready_o,
    output send_ready_data_o, send_ready_write_en_o
  );

  modport master (
    output grant_pkt_empty_i, grant_pkt_data_i,
    output rpc_reg_valid_i, rpc_reg_data_i,
    output send_ready_full_i,
    input  grant_pkt_read_en_o, rpc_reg_ready_o,
    input  send_ready_data_o, send_ready_write_en_o
  );

endinterface

// File: rtl/srpt_grant_recv_table.sv
// Per-RPC outbound message table: one combinational read port, one write port.
// Only the valid bits are reset; payload lives in plain storage.
module srpt_grant_table
  import homa_grant_pkg::*;
#(
  parameter int NUM_RPCS = 16,
  parameter int IDX_W    = $clog2(NUM_RPCS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output rpc_entry_t       rd_entry_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  rpc_entry_t       wr_entry_i
);

  logic       valid_q [NUM_RPCS];
  rpc_entry_t mem_q   [NUM_RPCS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RPCS; gi++) begin : g_valid
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          valid_q[gi] <= 1'b0;
        end else if (wr_en_i && (wr_idx_i == IDX_W'(gi))) begin
          valid_q[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_entry_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_entry_o = mem_q[rd_idx_i];

endmodule

// File: rtl/srpt_grant_recv.sv
// Grant receiver: pops grants, matches them to registered RPCs, clamps to msg_len
// and pushes grant-advance records. Optional event counters: GRANT_STATS_EN.
module srpt_grant_recv
  import homa_grant_pkg::*;
#(
  parameter int NUM_RPCS = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  srpt_grant_recv_if.slave bus,
  output logic [15:0]      stat_accepted_o,
  output logic [15:0]      stat_stale_o,
  output logic [15:0]      stat_unknown_o
);

  localparam int IDX_W = $clog2(NUM_RPCS);

  state_e                  state_q, state_d;
  logic                    alive_q;
  logic [RPC_ID_W-1:0]     rpc_id_q, rpc_id_d;
  logic [OFFSET_W-1:0]     offset_q, offset_d;
  logic [PRIO_W-1:0]       prio_q, prio_d;
  rpc_entry_t              entry_q, entry_d;
  logic [SEND_READY_W-1:0] rec_q, rec_d;

  logic                    rd_valid;
  rpc_entry_t              rd_entry;
  logic                    tbl_we;
  logic [IDX_W-1:0]        tbl_widx;
  rpc_entry_t              tbl_wentry;

  logic [OFFSET_W-1:0]     new_grant;
  logic                    read_en, write_en, reg_ready;
  logic                    ev_accept, ev_stale, ev_unknown;

  logic [RPC_ID_W-1:0]     reg_rpc, pkt_rpc;
  logic [PEER_ID_W-1:0]    reg_peer;
  logic [OFFSET_W-1:0]     reg_len, pkt_off;
  logic [PRIO_W-1:0]       pkt_prio;
  logic                    unused_grant_bits;

  assign reg_rpc  = bus.rpc_reg_data_i[RR_RPC_LSB +: RPC_ID_W];
  assign reg_peer = bus.rpc_reg_data_i[RR_PEER_LSB +: PEER_ID_W];
  assign reg_len  = bus.rpc_reg_data_i[RR_LEN_LSB +: OFFSET_W];
  assign pkt_rpc  = bus.grant_pkt_data_i[GP_RPC_LSB +: RPC_ID_W];
  assign pkt_off  = bus.grant_pkt_data_i[GP_OFF_LSB +: OFFSET_W];
  assign pkt_prio = bus.grant_pkt_data_i[GP_PRIO_LSB +: PRIO_W];
  // The packet's peer_id is not trusted; the table copy is emitted instead.
  assign unused_grant_bits = ^{bus.grant_pkt_data_i[GP_PEER_LSB +: PEER_ID_W],
                               bus.grant_pkt_data_i[GP_PRIO_LSB-1:0]};

  srpt_grant_table #(
    .NUM_RPCS (NUM_RPCS),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk_i      (ap_clk),
    .rst_ni     (ap_rst_n),
    .rd_idx_i   (rpc_id_q[IDX_W-1:0]),
    .rd_valid_o (rd_valid),
    .rd_entry_o (rd_entry),
    .wr_en_i    (tbl_we),
    .wr_idx_i   (tbl_widx),
    .wr_entry_i (tbl_wentry)
  );

  // alive_q holds the FSM off for the first edge after reset release.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      alive_q  <= 1'b0;
      rpc_id_q <= '0;
      offset_q <= '0;
      prio_q   <= '0;
      entry_q  <= '0;
      rec_q    <= '0;
    end else begin
      state_q  <= state_d;
      alive_q  <= 1'b1;
      rpc_id_q <= rpc_id_d;
      offset_q <= offset_d;
      prio_q   <= prio_d;
      entry_q  <= entry_d;
      rec_q    <= rec_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rpc_id_d   = rpc_id_q;
    offset_d   = offset_q;
    prio_d     = prio_q;
    entry_d    = entry_q;
    rec_d      = rec_q;
    read_en    = 1'b0;
    write_en   = 1'b0;
    reg_ready  = 1'b0;
    tbl_we     = 1'b0;
    tbl_widx   = rpc_id_q[IDX_W-1:0];
    tbl_wentry = entry_q;
    ev_accept  = 1'b0;
    ev_stale   = 1'b0;
    ev_unknown = 1'b0;
    new_grant  = clamp_grant(offset_q, entry_q.msg_len);

    unique case (state_q)
      IDLE: begin
        reg_ready = alive_q;
        // Registration has priority over popping a grant.
        if (alive_q && bus.rpc_reg_valid_i) begin
          tbl_we             = 1'b1;
          tbl_widx           = reg_rpc[IDX_W-1:0];
          tbl_wentry.tag     = reg_rpc;
          tbl_wentry.peer    = reg_peer;
          tbl_wentry.msg_len = reg_len;
          tbl_wentry.granted = '0;
        end else if (alive_q && !bus.grant_pkt_empty_i) begin
          read_en  = 1'b1;
          rpc_id_d = pkt_rpc;
          offset_d = pkt_off;
          prio_d   = pkt_prio;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (rd_valid && (rd_entry.tag == rpc_id_q)) begin
          entry_d = rd_entry;
          state_d = UPDATE;
        end else begin
          ev_unknown = 1'b1;
          state_d    = IDLE;
        end
      end
      UPDATE: begin
        if (new_grant <= entry_q.granted) begin
          ev_stale = 1'b1;
          state_d  = IDLE;
        end else begin
          tbl_we             = 1'b1;
          tbl_wentry.granted = new_grant;
          rec_d              = {entry_q.peer, rpc_id_q, prio_q, entry_q.granted, new_grant};
          state_d            = EMIT;
        end
      end
      EMIT: begin
        if (!bus.send_ready_full_i) begin
          write_en  = 1'b1;
          ev_accept = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant_pkt_read_en_o   = read_en;
  assign bus.rpc_reg_ready_o       = reg_ready;
  assign bus.send_ready_data_o     = rec_q;
  assign bus.send_ready_write_en_o = write_en;

`ifdef GRANT_STATS_EN
  logic [2:0]  ev_vec;
  logic [15:0] cnt_q [3];

  assign ev_vec = {ev_unknown, ev_stale, ev_accept};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stat
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          cnt_q[gi] <= '0;
        end else if (ev_vec[gi] && (cnt_q[gi] != 16'hFFFF)) begin
          cnt_q[gi] <= cnt_q[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign stat_accepted_o = cnt_q[0];
  assign stat_stale_o    = cnt_q[1];
  assign stat_unknown_o  = cnt_q[2];
`else
  logic unused_events;
  assign unused_events   = ev_accept ^ ev_stale ^ ev_unknown;
  assign stat_accepted_o = '0;
  assign stat_stale_o    = '0;
  assign stat_unknown_o  = '0;
`endif

endmodule
